// File: rtl/div_pkg.sv
// Shared state type, width constants and two's-complement helpers for seq_divider_6bit.
package div_pkg;

  localparam int WIDTH = 6;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] Q_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // The most-negative value maps onto itself, which reads as the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs2c(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg2c(v) : v;
  endfunction

endpackage

// File: rtl/seq_divider_6bit_if.sv
// Start/result bundle between the ALU sequencer (master) and seq_divider_6bit (slave).
// The overflow signal exists only when DIV_SIGNED_EN is defined.
interface seq_divider_6bit_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef DIV_SIGNED_EN
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/FullAdder.sv
// One-bit full adder cell used to build ripple datapaths.
module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/div_sub_step.sv
// Ripple trial subtractor a - b: inverted b plus carry-in 1; carry-out high means a >= b.
module div_sub_step #(
  parameter int W = 7
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_nonneg
);

  logic [W:0]   w_carry;
  logic [W-1:0] w_b_inv;

  assign w_b_inv    = i_b ^ {W{1'b1}};
  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    FullAdder u_fa (
      .i_a    (i_a[gi]),
      .i_b    (w_b_inv[gi]),
      .i_cin  (w_carry[gi]),
      .o_sum  (o_diff[gi]),
      .o_cout (w_carry[gi+1])
    );
  end

  assign o_nonneg = w_carry[W];

endmodule

// File: rtl/seq_divider_6bit.sv
// Multi-cycle restoring divider: one shift-subtract step per clock, results on a done pulse.
// Defining DIV_SIGNED_EN switches to two's-complement operands and adds an overflow flag.
module seq_divider_6bit
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_6bit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_by_zero;
`ifdef DIV_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ovf_pend;
  logic             r_overflow;
`endif

  logic [WIDTH:0]   w_shift_acc;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_acc_next;
  logic             w_nonneg;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;
  logic [WIDTH-1:0] w_dividend_in;
  logic [WIDTH-1:0] w_divisor_in;
  logic             w_unused;

  // The accumulator stays below the divisor between steps, so its top bit never feeds the shift.
  assign w_shift_acc = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_unused    = r_acc[WIDTH];

  div_sub_step #(.W(WIDTH + 1)) u_sub (
    .i_a      (w_shift_acc),
    .i_b      ({1'b0, r_divisor}),
    .o_diff   (w_trial),
    .o_nonneg (w_nonneg)
  );

  assign w_acc_next = w_nonneg ? w_trial : w_shift_acc;
  assign w_q_next   = {r_q[WIDTH-2:0], w_nonneg};

  // Operand conditioning at accept and sign fix-up of the final step's result.
  always_comb begin
    w_dividend_in = bus.dividend;
    w_divisor_in  = bus.divisor;
    w_q_res       = w_q_next;
    w_r_res       = w_acc_next[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    w_dividend_in = abs2c(bus.dividend);
    w_divisor_in  = abs2c(bus.divisor);
    if (r_neg_q) begin
      w_q_res = neg2c(w_q_next);
    end else begin
      w_q_res = w_q_next;
    end
    if (r_neg_r) begin
      w_r_res = neg2c(w_acc_next[WIDTH-1:0]);
    end else begin
      w_r_res = w_acc_next[WIDTH-1:0];
    end
`endif
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_acc         <= {(WIDTH+1){1'b0}};
      r_q           <= {WIDTH{1'b0}};
      r_divisor     <= {WIDTH{1'b0}};
      r_quotient    <= {WIDTH{1'b0}};
      r_remainder   <= {WIDTH{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_ovf_pend    <= 1'b0;
      r_overflow    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_overflow    <= 1'b0;
            r_neg_q       <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r       <= bus.dividend[WIDTH-1];
            r_ovf_pend    <= (bus.dividend == MOST_NEG) && (bus.divisor == Q_ALL_ONES);
`endif
            if (bus.divisor == {WIDTH{1'b0}}) begin
              r_state       <= DONE;
              r_done        <= 1'b1;
              r_quotient    <= Q_ALL_ONES;
              r_remainder   <= bus.dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_state   <= CALC;
              r_busy    <= 1'b1;
              r_acc     <= {(WIDTH+1){1'b0}};
              r_cnt     <= CNT_INIT;
              r_q       <= w_dividend_in;
              r_divisor <= w_divisor_in;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CNT_LAST;
          if (r_cnt == CNT_LAST) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_res;
            r_remainder <= w_r_res;
`ifdef DIV_SIGNED_EN
            r_overflow  <= r_ovf_pend;
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
`ifdef DIV_SIGNED_EN
  assign bus.overflow    = r_overflow;
`endif

endmodule

// File: tb/tb_seq_divider_6bit.sv
// Randomized self-checking bench for seq_divider_6bit against an arithmetic reference model.
// Follows DIV_SIGNED_EN the same way the design does.
module tb_seq_divider_6bit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
`ifdef DIV_SIGNED_EN
  int   m_ovf;
`endif

  seq_divider_6bit_if dif();

  seq_divider_6bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on 6-bit operand values.
  task automatic model(input int a, input int b, output int q, output int r, output int dbz);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
    m_ovf = 0;
`endif
    dbz = 0;
    if (b == 0) begin
      q = 63;
      r = a;
      dbz = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = (a >= 32) ? a - 64 : a;
      sb = (b >= 32) ? b - 64 : b;
      if (sa == -32 && sb == -1) begin
        q = 32;
        r = 0;
        m_ovf = 1;
      end else begin
        q = (sa / sb) & 63;
        r = (sa % sb) & 63;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one division from a settled point (#1 after an edge) and checks the whole transaction.
  task automatic do_div(input string tag, input int a, input int b);
    int q, r, dbz, k, busy_n, exp_lat;
    model(a, b, q, r, dbz);
    exp_lat = (b == 0) ? 0 : 6;
    dif.start    = 1'b1;
    dif.dividend = 6'(a);
    dif.divisor  = 6'(b);
    tick();
    dif.start = 1'b0;
    k = 0;
    busy_n = 0;
    while (dif.done !== 1'b1 && k < 20) begin
      if (k == 0) check({tag, ".dbz_clr"}, int'(dif.div_by_zero), 0);
      busy_n += int'(dif.busy);
      tick();
      k++;
    end
    check({tag, ".lat"}, k, exp_lat);
    check({tag, ".busy_cyc"}, busy_n, exp_lat);
    check({tag, ".busy_done"}, int'(dif.busy), 0);
    check({tag, ".q"}, int'(dif.quotient), q);
    check({tag, ".r"}, int'(dif.remainder), r);
    check({tag, ".dbz"}, int'(dif.div_by_zero), dbz);
`ifdef DIV_SIGNED_EN
    check({tag, ".ovf"}, int'(dif.overflow), m_ovf);
`endif
    tick();
    check({tag, ".pulse"}, int'(dif.done), 0);
    check({tag, ".hold_q"}, int'(dif.quotient), q);
    check({tag, ".hold_r"}, int'(dif.remainder), r);
  endtask

  initial begin
    int q, r, dbz, k, n_done, gap, a, b;

    rst_n        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = 6'd0;
    dif.divisor  = 6'd0;
    repeat (3) tick();
    check("rst.busy", int'(dif.busy), 0);
    check("rst.done", int'(dif.done), 0);
    check("rst.q", int'(dif.quotient), 0);
    check("rst.r", int'(dif.remainder), 0);
    check("rst.dbz", int'(dif.div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    do_div("d45_6", 45, 6);
    do_div("d63_1", 63, 1);
    do_div("d5_9", 5, 9);
    do_div("d17_0", 17, 0);
    do_div("d20_4", 20, 4);
    do_div("d0_7", 0, 7);
    do_div("d63_63", 63, 63);
    do_div("dm20_3", 44, 3);
    do_div("dm32_m1", 32, 63);

    // start raised mid-calculation must be ignored
    model(45, 6, q, r, dbz);
    dif.start = 1'b1; dif.dividend = 6'd45; dif.divisor = 6'd6;
    tick();
    dif.start = 1'b0;
    k = 0;
    while (dif.done !== 1'b1 && k < 20) begin
      if (k == 2) begin
        dif.start = 1'b1; dif.dividend = 6'd10; dif.divisor = 6'd2;
      end
      if (k == 4) dif.start = 1'b0;
      tick();
      k++;
    end
    check("busy_ign.lat", k, 6);
    check("busy_ign.q", int'(dif.quotient), q);
    check("busy_ign.r", int'(dif.remainder), r);
    n_done = 0;
    repeat (12) begin
      tick();
      n_done += int'(dif.done);
    end
    check("busy_ign.no_2nd_done", n_done, 0);
    do_div("after", 10, 2);

    // asynchronous reset in the middle of a calculation
    dif.start = 1'b1; dif.dividend = 6'd45; dif.divisor = 6'd6;
    tick();
    dif.start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", int'(dif.busy), 0);
    check("arst.done", int'(dif.done), 0);
    check("arst.q", int'(dif.quotient), 0);
    check("arst.r", int'(dif.remainder), 0);
    check("arst.dbz", int'(dif.div_by_zero), 0);
    tick();
    check("arst.busy_held", int'(dif.busy), 0);
    rst_n = 1'b1;
    tick();
    do_div("post_rst", 20, 4);

    // start held high retriggers: DONE, IDLE, accept, six steps -> eight edges between pulses
    model(12, 5, q, r, dbz);
    dif.start = 1'b1; dif.dividend = 6'd12; dif.divisor = 6'd5;
    k = 0;
    while (dif.done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("retrig.first_lat", k, 7);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (dif.done !== 1'b1 && gap < 20);
    dif.start = 1'b0;
    check("retrig.gap", gap, 8);
    check("retrig.q", int'(dif.quotient), q);
    check("retrig.r", int'(dif.remainder), r);
    repeat (2) tick();

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 63));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      do_div($sformatf("rnd%0d", i), a, b);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
